// File: rtl/dctq_pkg.sv
// Shared constants for the DCTQ coefficient ROM: the 8x8 DCT matrix,
// its dimensions and the sweep sequencer state encoding.
package dctq_pkg;

  localparam int DCT_N  = 8;
  localparam int ADDR_W = 3;

  // Row r, element 0 first; 8-bit two's complement, scaled DCT basis.
  localparam logic [7:0] C_TAB [DCT_N][DCT_N] = '{
    '{8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B},
    '{8'h7E, 8'h6A, 8'h47, 8'h19, 8'hE7, 8'hB9, 8'h96, 8'h82},
    '{8'h76, 8'h31, 8'hCF, 8'h8A, 8'h8A, 8'hCF, 8'h31, 8'h76},
    '{8'h6A, 8'hE7, 8'h82, 8'hB9, 8'h47, 8'h7E, 8'h19, 8'h96},
    '{8'h5B, 8'hA5, 8'hA5, 8'h5B, 8'h5B, 8'hA5, 8'hA5, 8'h5B},
    '{8'h47, 8'h82, 8'h19, 8'h6A, 8'h96, 8'hE7, 8'h7E, 8'hB9},
    '{8'h31, 8'h8A, 8'h76, 8'hCF, 8'hCF, 8'h76, 8'h8A, 8'h31},
    '{8'h19, 8'hB9, 8'h6A, 8'h82, 8'h7E, 8'h96, 8'h47, 8'hE7}
  };

  typedef enum logic {IDLE, RUN} seq_state_t;

endpackage

// File: rtl/dct_coef_lut.sv
// Combinational lookup of one row or column of the DCT matrix, each
// element sign-extended to COEF_W; element 0 lands in the top slot.
module dct_coef_lut
  import dctq_pkg::*;
#(
  parameter int COEF_W = 8
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    mode,
  output logic [DCT_N*COEF_W-1:0] coef
);

  for (genvar gi = 0; gi < DCT_N; gi++) begin : g_elem
    logic [7:0] raw;
    assign raw = mode ? C_TAB[gi][addr] : C_TAB[addr][gi];
    if (COEF_W > 8) begin : g_ext
      assign coef[(DCT_N-gi)*COEF_W-1 -: COEF_W] = {{(COEF_W-8){raw[7]}}, raw};
    end else begin : g_noext
      assign coef[(DCT_N-gi)*COEF_W-1 -: COEF_W] = raw;
    end
  end

endmodule

// File: rtl/dct_coef_rom_pipe.sv
// Multi-port DCT coefficient ROM with a PIPE-deep globally stalled
// valid/ready pipeline and an optional internal 0..7 address sweep.
module dct_coef_rom_pipe
  import dctq_pkg::*;
#(
  parameter int NPORT  = 2,
  parameter int PIPE   = 2,
  parameter int COEF_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NPORT*ADDR_W-1:0]         addr,
  input  logic [NPORT-1:0]                mode,
  input  logic [TAG_W-1:0]                in_tag,
  input  logic                            seq_start,
  input  logic                            seq_mode,
  output logic                            seq_busy,
  output logic                            seq_done,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NPORT*DCT_N*COEF_W-1:0]   dout,
  output logic [TAG_W-1:0]                out_tag
);

  localparam int PORT_W = DCT_N*COEF_W;
  localparam int DW     = NPORT*PORT_W;

  seq_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              mode_reg, mode_next;

  logic              stall;
  logic              busy;
  logic              valid_in;
  logic [TAG_W-1:0]  tag_in;
  logic [DW-1:0]     lut_data;

  assign busy     = (state_reg == RUN);
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~busy;
  assign seq_busy = busy;

  // During a sweep the sequencer owns every port; external requests are ignored.
  assign valid_in = busy | in_valid;
  assign tag_in   = busy ? TAG_W'(cnt_reg) : in_tag;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    logic [ADDR_W-1:0] addr_sel;
    logic              mode_sel;
    assign addr_sel = busy ? cnt_reg  : addr[gi*ADDR_W +: ADDR_W];
    assign mode_sel = busy ? mode_reg : mode[gi];
    dct_coef_lut #(.COEF_W(COEF_W)) u_lut (
      .addr (addr_sel),
      .mode (mode_sel),
      .coef (lut_data[gi*PORT_W +: PORT_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    seq_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (seq_start) begin
          state_next = RUN;
          cnt_next   = '0;
          mode_next  = seq_mode;
        end
      end
      RUN: begin
        if (!stall) begin
          cnt_next = cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) begin
            seq_done   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every stage, bubbles included, freezes while the output is stalled.
  logic              v_reg [PIPE];
  logic [TAG_W-1:0]  t_reg [PIPE];
  logic [DW-1:0]     d_reg [PIPE];

  for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
    logic             v_in;
    logic [TAG_W-1:0] t_in;
    logic [DW-1:0]    d_in;
    if (gi == 0) begin : g_first
      assign v_in = valid_in;
      assign t_in = tag_in;
      assign d_in = lut_data;
    end else begin : g_next
      assign v_in = v_reg[gi-1];
      assign t_in = t_reg[gi-1];
      assign d_in = d_reg[gi-1];
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_reg[gi] <= 1'b0;
        t_reg[gi] <= '0;
        d_reg[gi] <= '0;
      end else if (!stall) begin
        v_reg[gi] <= v_in;
        t_reg[gi] <= t_in;
        d_reg[gi] <= d_in;
      end
    end
  end

  assign out_valid = v_reg[PIPE-1];
  assign out_tag   = t_reg[PIPE-1];
  assign dout      = d_reg[PIPE-1];

endmodule
